// File: rtl/icache_dm_if.sv
// Shared widths plus the PC-side fetch interface and the AXI read-channel
// interface used by the instruction cache.
package _riscv_defines;
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
endpackage

interface pc_icache_if;
    import _riscv_defines::*;
    logic [ADDR_WIDTH-1:0] pc_addr;
    logic                  pc_valid;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;

    modport icache (input pc_addr, pc_valid, output instruction, instr_valid);
    modport pc     (output pc_addr, pc_valid, input instruction, instr_valid);
endinterface

interface axi_read_if;
    import _riscv_defines::*;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic                      rlast;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (output araddr, arlen, arsize, arburst, arvalid, rready,
                    input  arready, rdata, rlast, rresp, rvalid);
    modport slave  (input  araddr, arlen, arsize, arburst, arvalid, rready,
                    output arready, rdata, rlast, rresp, rvalid);
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache; misses refill a whole line with
// one AXI INCR burst, and flush invalidates every line.
module icache_dm #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    pc_icache_if.icache pc_if,
    axi_read_if.master  axi_if
);
    localparam int ADDR_W = 32;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int CNT_W  = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    logic [ADDR_W-3:0] req_q;
    logic              instr_valid_q;
    logic [31:0]       instruction_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic              err_q;
    logic              flush_pend_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              hit;

    logic [OFF_W-1:0] pc_off, req_off;
    logic [IDX_W-1:0] pc_idx, req_idx;
    logic [TAG_W-1:0] pc_tag, req_tag;
    logic             unused_byte_bits;

    assign pc_off  = pc_if.pc_addr[2 +: OFF_W];
    assign pc_idx  = pc_if.pc_addr[OFF_W+2 +: IDX_W];
    assign pc_tag  = pc_if.pc_addr[ADDR_W-1 -: TAG_W];
    assign req_off = req_q[0 +: OFF_W];
    assign req_idx = req_q[OFF_W +: IDX_W];
    assign req_tag = req_q[ADDR_W-3 -: TAG_W];
    assign unused_byte_bits = ^pc_if.pc_addr[1:0];

    assign pc_if.instr_valid = instr_valid_q;
    assign pc_if.instruction = instruction_q;
    assign axi_if.araddr     = araddr_q;
    assign axi_if.arlen      = arlen_q;
    assign axi_if.arsize     = 3'b010;
    assign axi_if.arburst    = 2'b01;
    assign axi_if.arvalid    = arvalid_q;
    assign axi_if.rready     = rready_q;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hit     = 1'b0;
        case (state_q)
            IDLE: begin
                // The cycle right after a response is blocked so a held pc_valid is not served twice.
                if (pc_if.pc_valid && !instr_valid_q) begin
                    accept = 1'b1;
                    hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !flush;
                    if (!hit) state_d = AR;
                end
            end
            AR:      if (axi_if.arready) state_d = R;
            R:       if (axi_if.rvalid && axi_if.rlast) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            req_q         <= '0;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            err_q         <= 1'b0;
            flush_pend_q  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) valid_q <= '0;
                    if (accept) begin
                        req_q <= pc_if.pc_addr[ADDR_W-1:2];
                        if (hit) begin
                            instr_valid_q <= 1'b1;
                            instruction_q <= data_q[pc_idx][pc_off];
                        end else begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= {pc_if.pc_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                            arlen_q   <= 8'(LINE_WORDS - 1);
                        end
                    end
                end
                AR: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (axi_if.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                R: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (axi_if.rvalid) begin
                        // A bad response or rlast out of step with the counter poisons the fill.
                        if (axi_if.rresp != 2'b00) err_q <= 1'b1;
                        if (axi_if.rlast != (cnt_q == CNT_W'(LINE_WORDS - 1))) err_q <= 1'b1;
                        if (cnt_q != CNT_W'(LINE_WORDS)) cnt_q <= cnt_q + 1'b1;
                        if (axi_if.rlast) rready_q <= 1'b0;
                    end
                end
                RESP: begin
                    instr_valid_q <= 1'b1;
                    instruction_q <= data_q[req_idx][req_off];
                    if (flush || flush_pend_q) valid_q <= '0;
                    else valid_q[req_idx] <= !err_q;
                    flush_pend_q <= 1'b0;
                    err_q        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (state_q == R && axi_if.rvalid && !cnt_q[OFF_W])
            data_q[req_idx][cnt_q[OFF_W-1:0]] <= axi_if.rdata;
        if (state_q == RESP)
            tag_q[req_idx] <= req_tag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a cycle-stepped AXI slave model inside a fetch
// helper, with each scenario task checking its own hand-computed results.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pc_icache_if pc_bus();
    axi_read_if  axi_bus();

    icache_dm #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .pc_if  (pc_bus),
        .axi_if (axi_bus)
    );

    int checks = 0;
    int errors = 0;

    logic        f_done;
    int          f_lat;
    int          f_ar_cycles;
    int          f_beats;
    logic        f_ar_moved;
    logic [31:0] f_instr;
    logic [31:0] f_araddr;
    logic [7:0]  f_arlen;
    logic [2:0]  f_arsize;
    logic [1:0]  f_arburst;

    // Line 0x100 holds 0x11..0x44; every other line holds base+word_index.
    function automatic logic [31:0] slave_word(input logic [31:0] base, input int k);
        if (base == 32'h100) return 32'(32'h11 * (k + 1));
        return base + 32'(k);
    endfunction

    task automatic fetch(input logic [31:0] addr, input int ar_wait, input int gap,
                         input int err_beat, input int flush_beat);
        int arw;
        int gapc;
        int beat;
        f_done = 1'b0; f_lat = 0; f_ar_cycles = 0; f_beats = 0; f_ar_moved = 1'b0;
        f_instr = '0; f_araddr = '0; f_arlen = '0; f_arsize = '0; f_arburst = '0;
        arw = 0; gapc = gap; beat = 0;
        @(negedge clk);
        pc_bus.pc_addr  = addr;
        pc_bus.pc_valid = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
            axi_bus.rresp = 2'b00; flush = 1'b0;
            if (pc_bus.instr_valid) begin
                f_done = 1'b1; f_lat = cyc; f_instr = pc_bus.instruction;
                pc_bus.pc_valid = 1'b0;
                break;
            end
            if (axi_bus.arvalid) begin
                if (f_ar_cycles == 0) begin
                    f_araddr = axi_bus.araddr; f_arlen = axi_bus.arlen;
                    f_arsize = axi_bus.arsize; f_arburst = axi_bus.arburst;
                end else if (axi_bus.araddr !== f_araddr) f_ar_moved = 1'b1;
                f_ar_cycles++;
                if (arw >= ar_wait) axi_bus.arready = 1'b1;
                else arw++;
            end
            if (axi_bus.rready) begin
                if (gapc >= gap) begin
                    gapc = 0;
                    axi_bus.rvalid = 1'b1;
                    axi_bus.rdata  = slave_word(f_araddr, beat);
                    axi_bus.rlast  = (beat == 3);
                    if (beat == err_beat) axi_bus.rresp = 2'b10;
                    if (beat == flush_beat) flush = 1'b1;
                    beat++; f_beats++;
                end else gapc++;
            end
        end
        pc_bus.pc_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        pc_bus.pc_addr = '0; pc_bus.pc_valid = 1'b0;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
        axi_bus.rresp = 2'b00; axi_bus.rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (pc_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", pc_bus.instr_valid); end
        checks++; if (pc_bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h expected 0", pc_bus.instruction); end
        checks++; if (axi_bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", axi_bus.arvalid); end
        checks++; if (axi_bus.rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", axi_bus.rready); end
        checks++; if (axi_bus.araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", axi_bus.araddr); end
        checks++; if (axi_bus.arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h expected 0", axi_bus.arlen); end
    endtask

    task automatic test_cold_miss();
        fetch(32'h104, 0, 0, -1, -1);
        checks++; if (f_done !== 1'b1) begin errors++; $display("FAIL cold_done: got %b expected 1", f_done); end
        checks++; if (f_instr !== 32'h22) begin errors++; $display("FAIL cold_instr: got %h expected 00000022", f_instr); end
        checks++; if (f_araddr !== 32'h100) begin errors++; $display("FAIL cold_araddr: got %h expected 00000100", f_araddr); end
        checks++; if (f_arlen !== 8'd3) begin errors++; $display("FAIL cold_arlen: got %0d expected 3", f_arlen); end
        checks++; if (f_arburst !== 2'b01) begin errors++; $display("FAIL cold_arburst: got %b expected 01", f_arburst); end
        checks++; if (f_arsize !== 3'b010) begin errors++; $display("FAIL cold_arsize: got %b expected 010", f_arsize); end
        checks++; if (f_lat !== 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", f_lat); end
        checks++; if (f_beats !== 4) begin errors++; $display("FAIL cold_beats: got %0d expected 4", f_beats); end
        @(negedge clk);
        checks++; if (pc_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL cold_pulse: got %b expected 0", pc_bus.instr_valid); end
    endtask

    task automatic test_hit();
        fetch(32'h10C, 0, 0, -1, -1);
        checks++; if (f_instr !== 32'h44) begin errors++; $display("FAIL hit_instr: got %h expected 00000044", f_instr); end
        checks++; if (f_lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", f_lat); end
        checks++; if (f_ar_cycles !== 0) begin errors++; $display("FAIL hit_no_ar: got %0d expected 0", f_ar_cycles); end
        @(negedge clk);
        checks++; if (pc_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %b expected 0", pc_bus.instr_valid); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        pc_bus.pc_addr = 32'h108; pc_bus.pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_bus.instr_valid) pulses++;
        end
        pc_bus.pc_valid = 1'b0;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (pc_bus.instruction !== 32'h33) begin errors++; $display("FAIL b2b_instr: got %h expected 00000033", pc_bus.instruction); end
    endtask

    task automatic test_conflict();
        fetch(32'h504, 0, 0, -1, -1);
        checks++; if (f_araddr !== 32'h500 || f_ar_cycles == 0) begin errors++; $display("FAIL conflict_miss: araddr %h ar_cycles %0d expected 00000500 and >0", f_araddr, f_ar_cycles); end
        checks++; if (f_instr !== 32'h501) begin errors++; $display("FAIL conflict_instr: got %h expected 00000501", f_instr); end
        fetch(32'h104, 0, 0, -1, -1);
        checks++; if (f_ar_cycles == 0 || f_araddr !== 32'h100) begin errors++; $display("FAIL conflict_refetch: araddr %h ar_cycles %0d expected 00000100 and >0", f_araddr, f_ar_cycles); end
        checks++; if (f_instr !== 32'h22) begin errors++; $display("FAIL conflict_refetch_instr: got %h expected 00000022", f_instr); end
    endtask

    task automatic test_slow_slave();
        fetch(32'h508, 5, 2, -1, -1);
        checks++; if (f_ar_moved !== 1'b0) begin errors++; $display("FAIL slow_araddr_stable: got moved=%b expected 0", f_ar_moved); end
        checks++; if (f_ar_cycles !== 6) begin errors++; $display("FAIL slow_ar_cycles: got %0d expected 6", f_ar_cycles); end
        checks++; if (f_instr !== 32'h502) begin errors++; $display("FAIL slow_instr: got %h expected 00000502", f_instr); end
        checks++; if (f_lat !== 18) begin errors++; $display("FAIL slow_latency: got %0d expected 18", f_lat); end
        checks++; if (f_beats !== 4 || axi_bus.rready !== 1'b0) begin errors++; $display("FAIL slow_beats: beats %0d rready %b expected 4 and 0", f_beats, axi_bus.rready); end
        fetch(32'h50C, 0, 0, -1, -1);
        checks++; if (f_lat !== 1 || f_instr !== 32'h503) begin errors++; $display("FAIL slow_hit: latency %0d instr %h expected 1 and 00000503", f_lat, f_instr); end
    endtask

    task automatic test_slverr();
        fetch(32'h704, 0, 0, 2, -1);
        checks++; if (f_done !== 1'b1 || f_instr !== 32'h701) begin errors++; $display("FAIL slverr_response: done %b instr %h expected 1 and 00000701", f_done, f_instr); end
        fetch(32'h704, 0, 0, -1, -1);
        checks++; if (f_ar_cycles == 0 || f_araddr !== 32'h700) begin errors++; $display("FAIL slverr_refetch: araddr %h ar_cycles %0d expected 00000700 and >0", f_araddr, f_ar_cycles); end
        fetch(32'h704, 0, 0, -1, -1);
        checks++; if (f_lat !== 1 || f_instr !== 32'h701) begin errors++; $display("FAIL slverr_clean_hit: latency %0d instr %h expected 1 and 00000701", f_lat, f_instr); end
    endtask

    task automatic test_flush();
        fetch(32'h904, 0, 0, -1, 1);
        checks++; if (f_instr !== 32'h901) begin errors++; $display("FAIL flush_r_instr: got %h expected 00000901", f_instr); end
        fetch(32'h904, 0, 0, -1, -1);
        checks++; if (f_ar_cycles == 0) begin errors++; $display("FAIL flush_r_refetch: got ar_cycles %0d expected >0", f_ar_cycles); end
        fetch(32'h904, 0, 0, -1, -1);
        checks++; if (f_lat !== 1) begin errors++; $display("FAIL flush_prehit: got latency %0d expected 1", f_lat); end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        fetch(32'h904, 0, 0, -1, -1);
        checks++; if (f_ar_cycles == 0 || f_instr !== 32'h901) begin errors++; $display("FAIL flush_idle_miss: ar_cycles %0d instr %h expected >0 and 00000901", f_ar_cycles, f_instr); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_slow_slave();
        test_slverr();
        test_flush();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
